// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and constants for the TX frame scheduler and its arbiter.
package tx_frame_scheduler_pkg;

  // Scheduler FSM: wait for a winner, then push the low byte and, for ALU
  // results only, the high byte.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

  // Requester indices, also the bit positions in the request/grant vectors.
  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_RF  = 2'd1;
  localparam logic [1:0] REQ_ERR = 2'd2;

  // Next requester in the round-robin ring ALU -> RF -> ERR -> ALU.
  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return (idx == REQ_ERR) ? REQ_ALU : idx + 2'd1;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Three-way round-robin arbiter. The grant is combinational so the winner
// sees it in its request cycle; the priority pointer moves past the winner.
module rr_arbiter
  import tx_frame_scheduler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] cand;
  logic       candReq;

  // Walk the ring starting at the pointer and take the first active request.
  always_comb begin
    idx_o   = ptr_q;
    valid_o = 1'b0;
    cand    = ptr_q;
    candReq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      case (cand)
        REQ_ALU: candReq = req_i[0];
        REQ_RF:  candReq = req_i[1];
        REQ_ERR: candReq = req_i[2];
        default: candReq = 1'b0;
      endcase
      if (!valid_o && en_i && candReq) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
      cand = nextIdx(cand);
    end
    gnt_o = valid_o ? (3'b001 << idx_o) : 3'b000;
    ptr_d = valid_o ? nextIdx(idx_o) : ptr_q;
  end

  // Priority pointer only moves when a grant is actually issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares the TX FIFO write port among the ALU (two bytes, LSB first),
// RegFile and error/status sources, honouring FIFO_FULL backpressure.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ALU_REQ,
  input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
  output logic                    ALU_GNT,
  input  logic                    RF_REQ,
  input  logic [DATA_WIDTH-1:0]   RF_DATA,
  output logic                    RF_GNT,
  input  logic                    ERR_REQ,
  input  logic [DATA_WIDTH-1:0]   ERR_CODE,
  output logic                    ERR_GNT,
  input  logic                    FIFO_FULL,
  output logic                    FIFO_WR,
  output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
  output logic                    BUSY,
  output logic [CNT_WIDTH-1:0]    BYTE_CNT
);

  state_e                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
  logic                    isAlu_q, isAlu_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic [2:0] gntVec;
  logic [1:0] grantIdx;
  logic       grantValid;

  rr_arbiter uArb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (state_q == IDLE),
    .req_i   ({ERR_REQ, RF_REQ, ALU_REQ}),
    .gnt_o   (gntVec),
    .idx_o   (grantIdx),
    .valid_o (grantValid)
  );

  assign ALU_GNT  = gntVec[REQ_ALU];
  assign RF_GNT   = gntVec[REQ_RF];
  assign ERR_GNT  = gntVec[REQ_ERR];
  assign BUSY     = (state_q != IDLE);
  assign BYTE_CNT = cnt_q;

  // Write strike follows FIFO_FULL directly; the byte shown depends on phase.
  always_comb begin
    FIFO_WR      = (state_q != IDLE) && !FIFO_FULL;
    FIFO_WR_DATA = (state_q == SEND_HI) ? hold_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : hold_q[DATA_WIDTH-1:0];
  end

  // Next-state logic: capture the winner's data, then stall on full.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    isAlu_d = isAlu_q;
    cnt_d   = FIFO_WR ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    case (state_q)
      IDLE: begin
        if (grantValid) begin
          state_d = SEND_LO;
          isAlu_d = (grantIdx == REQ_ALU);
          case (grantIdx)
            REQ_ALU: hold_d = ALU_DATA;
            REQ_RF:  hold_d = {{DATA_WIDTH{1'b0}}, RF_DATA};
            default: hold_d = {{DATA_WIDTH{1'b0}}, ERR_CODE};
          endcase
        end
      end
      SEND_LO: begin
        if (!FIFO_FULL) begin
          state_d = isAlu_q ? SEND_HI : IDLE;
        end
      end
      SEND_HI: begin
        if (!FIFO_FULL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any half-sent transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      isAlu_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      isAlu_q <= isAlu_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: a per-cycle vector table plus
// hand-written reset-abort and counter-wrap sequences.
module tb_tx_frame_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_REQ;
  logic [15:0] ALU_DATA;
  logic        ALU_GNT;
  logic        RF_REQ;
  logic [7:0]  RF_DATA;
  logic        RF_GNT;
  logic        ERR_REQ;
  logic [7:0]  ERR_CODE;
  logic        ERR_GNT;
  logic        FIFO_FULL;
  logic        FIFO_WR;
  logic [7:0]  FIFO_WR_DATA;
  logic        BUSY;
  logic [7:0]  BYTE_CNT;

  typedef struct {
    logic        aluReq;
    logic [15:0] aluData;
    logic        rfReq;
    logic [7:0]  rfData;
    logic        errReq;
    logic [7:0]  errCode;
    logic        fifoFull;
    logic [2:0]  expGnt;
    logic        expWr;
    logic [7:0]  expData;
    logic        expBusy;
    logic [7:0]  expCnt;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 CLK = ~CLK;

  tx_frame_scheduler #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ALU_REQ      (ALU_REQ),
    .ALU_DATA     (ALU_DATA),
    .ALU_GNT      (ALU_GNT),
    .RF_REQ       (RF_REQ),
    .RF_DATA      (RF_DATA),
    .RF_GNT       (RF_GNT),
    .ERR_REQ      (ERR_REQ),
    .ERR_CODE     (ERR_CODE),
    .ERR_GNT      (ERR_GNT),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR      (FIFO_WR),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .BUSY         (BUSY),
    .BYTE_CNT     (BYTE_CNT)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ALU_REQ   = v.aluReq;
    ALU_DATA  = v.aluData;
    RF_REQ    = v.rfReq;
    RF_DATA   = v.rfData;
    ERR_REQ   = v.errReq;
    ERR_CODE  = v.errCode;
    FIFO_FULL = v.fifoFull;
  endtask

  task automatic addRow(input logic ar, input logic [15:0] ad, input logic rr, input logic [7:0] rd,
                        input logic er, input logic [7:0] ec, input logic ff, input logic [2:0] gnt,
                        input logic wr, input logic [7:0] wd, input logic busy, input logic [7:0] cnt);
    vec_t v;
    v.aluReq = ar;  v.aluData = ad;  v.rfReq = rr;   v.rfData = rd;
    v.errReq = er;  v.errCode = ec;  v.fifoFull = ff;
    v.expGnt = gnt; v.expWr = wr;    v.expData = wd; v.expBusy = busy; v.expCnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int writes;
    int cyc;

    // Each row is one clock: inputs for the cycle, outputs sampled before its edge.
    // gnt bits are {ERR, RF, ALU}.
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,0,8'h00,0,8'd0);   // idle after reset
    addRow(0,16'h0000,1,8'hA5,0,8'h00,0, 3'b010,0,8'h00,0,8'd0);   // RF granted same cycle
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,1,8'hA5,1,8'd0);   // RF byte written
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,0,8'h00,0,8'd1);   // back to idle
    addRow(1,16'h1234,0,8'h00,0,8'h00,0, 3'b001,0,8'h00,0,8'd1);   // ALU granted
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,1,8'h34,1,8'd1);   // low byte; data change ignored
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,1,8'h12,1,8'd2);   // high byte
    addRow(0,16'h0000,0,8'h00,1,8'h3C,0, 3'b100,0,8'h00,0,8'd3);   // ERR brings pointer to ALU
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,1,8'h3C,1,8'd3);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b001,0,8'h00,0,8'd4);   // all requesting
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b000,1,8'hEF,1,8'd4);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b000,1,8'hBE,1,8'd5);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b010,0,8'h00,0,8'd6);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b000,1,8'h11,1,8'd6);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b100,0,8'h00,0,8'd7);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b000,1,8'hE1,1,8'd7);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b001,0,8'h00,0,8'd8);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b000,1,8'hEF,1,8'd8);
    addRow(1,16'hBEEF,1,8'h11,1,8'hE1,0, 3'b000,1,8'hBE,1,8'd9);
    addRow(1,16'hCAFE,0,8'h00,0,8'h00,0, 3'b001,0,8'h00,0,8'd10);  // ALU wins from RF pointer
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,1,8'hFE,1,8'd10);
    addRow(0,16'h0000,0,8'h00,0,8'h00,1, 3'b000,0,8'h00,1,8'd11);  // high byte stalled
    addRow(0,16'h0000,0,8'h00,0,8'h00,1, 3'b000,0,8'h00,1,8'd11);
    addRow(0,16'h0000,0,8'h00,0,8'h00,1, 3'b000,0,8'h00,1,8'd11);
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,1,8'hCA,1,8'd11);
    addRow(0,16'h0000,1,8'h5A,0,8'h00,0, 3'b010,0,8'h00,0,8'd12);
    addRow(0,16'h0000,0,8'h00,0,8'h00,1, 3'b000,0,8'h00,1,8'd12);  // low byte stalled
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,1,8'h5A,1,8'd12);
    addRow(0,16'h0000,0,8'h00,0,8'h00,0, 3'b000,0,8'h00,0,8'd13);

    // Reset state
    RST = 1'b1; ALU_REQ = 0; ALU_DATA = '0; RF_REQ = 0; RF_DATA = '0;
    ERR_REQ = 0; ERR_CODE = '0; FIFO_FULL = 0;
    @(negedge CLK);
    checkOutput("rst_wr",   FIFO_WR, 0);
    checkOutput("rst_data", FIFO_WR_DATA, 8'h00);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_cnt",  BYTE_CNT, 0);
    checkOutput("rst_gnt",  {ERR_GNT, RF_GNT, ALU_GNT}, 3'b000);
    nextCycle();
    RST = 1'b0;

    // Table-driven sequence
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge CLK);
      checkOutput($sformatf("row%0d_gnt", i),  {ERR_GNT, RF_GNT, ALU_GNT}, vecs[i].expGnt);
      checkOutput($sformatf("row%0d_wr", i),   FIFO_WR, vecs[i].expWr);
      checkOutput($sformatf("row%0d_busy", i), BUSY, vecs[i].expBusy);
      checkOutput($sformatf("row%0d_cnt", i),  BYTE_CNT, vecs[i].expCnt);
      if (vecs[i].expWr)
        checkOutput($sformatf("row%0d_data", i), FIFO_WR_DATA, vecs[i].expData);
      nextCycle();
    end

    // Reset while the ALU high byte is pending
    ALU_REQ = 1; ALU_DATA = 16'h5566;
    @(negedge CLK);
    checkOutput("abort_gnt", ALU_GNT, 1);
    nextCycle();
    ALU_REQ = 0;
    @(negedge CLK);
    checkOutput("abort_lo_wr",   FIFO_WR, 1);
    checkOutput("abort_lo_data", FIFO_WR_DATA, 8'h66);
    nextCycle();
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abort_rst_wr",   FIFO_WR, 0);
    checkOutput("abort_rst_busy", BUSY, 0);
    checkOutput("abort_rst_cnt",  BYTE_CNT, 0);
    nextCycle();
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("abort_no_hi_wr", FIFO_WR, 0);
    nextCycle();
    RF_REQ = 1; RF_DATA = 8'h77;
    @(negedge CLK);
    checkOutput("abort_rf_gnt", {ERR_GNT, RF_GNT, ALU_GNT}, 3'b010);
    nextCycle();
    RF_REQ = 0;
    @(negedge CLK);
    checkOutput("abort_rf_wr",   FIFO_WR, 1);
    checkOutput("abort_rf_data", FIFO_WR_DATA, 8'h77);
    nextCycle();
    @(negedge CLK);
    checkOutput("abort_rf_single", FIFO_WR, 0);
    checkOutput("abort_rf_cnt",    BYTE_CNT, 1);
    nextCycle();

    // 256 RF writes under random backpressure wrap the counter to zero
    RST = 1'b1;
    nextCycle();
    RST = 1'b0;
    RF_REQ = 1; RF_DATA = 8'hC3;
    writes = 0;
    cyc = 0;
    while (writes < 256 && cyc < 3000) begin
      FIFO_FULL = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      if (FIFO_WR) begin
        checkOutput("wrap_wr_full", FIFO_FULL, 0);
        checkOutput("wrap_data", FIFO_WR_DATA, 8'hC3);
        if (writes == 255)
          checkOutput("wrap_cnt_max", BYTE_CNT, 8'd255);
        writes++;
      end
      nextCycle();
      cyc++;
    end
    checkOutput("wrap_writes", writes, 256);
    RF_REQ = 0; FIFO_FULL = 0;
    @(negedge CLK);
    checkOutput("wrap_cnt", BYTE_CNT, 8'd0);
    checkOutput("wrap_idle", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Shares the single write port of the TX async FIFO (REF_CLK domain) among three byte sources: ALU result (16-bit), RegFile read data (8-bit), and error/status code (8-bit).
- Round-robin arbitration between sources.
- Serialises the 16-bit ALU result into two bytes, LSB first.
- Honours FIFO_FULL backpressure.
- Sits between the system controller's result paths and the FIFO W_INC/WR_DATA inputs.

Parameters:
- DATA_WIDTH, 8, byte width of the FIFO and of the RF/ERR data.
- CNT_WIDTH, 8, width of the written-byte counter.

Ports:
- CLK  in  1  REF_CLK-domain clock
- RST  in  1  asynchronous, active-high reset
- ALU_REQ  in  1  ALU result pending; held until ALU_GNT
- ALU_DATA  in  2*DATA_WIDTH  ALU result; stable while ALU_REQ high
- ALU_GNT  out  1  one-cycle accept pulse
- RF_REQ  in  1  RegFile read byte pending
- RF_DATA  in  DATA_WIDTH  RegFile byte
- RF_GNT  out  1  accept pulse
- ERR_REQ  in  1  error/status byte pending
- ERR_CODE  in  DATA_WIDTH  error/status byte
- ERR_GNT  out  1  accept pulse
- FIFO_FULL  in  1  FIFO full flag
- FIFO_WR  out  1  FIFO write strike (W_INC)
- FIFO_WR_DATA  out  DATA_WIDTH  FIFO write data
- BUSY  out  1  transaction in progress
- BYTE_CNT  out  CNT_WIDTH  total bytes written, wraps

Behaviour:
Reset (RST=1, async) forces:
- state=IDLE, holding register=0, priority pointer=ALU.
- BYTE_CNT=0, FIFO_WR_DATA=0.
- FIFO_WR=0, all GNT=0, BUSY=0.
- Reset mid-transaction discards the pending bytes; no partial write follows.

States: IDLE, SEND_LO, SEND_HI.

IDLE:
- When any REQ is high, the arbiter picks a winner.
- The winner's GNT is asserted combinationally in the same cycle.
- Its data is captured into the holding register at the clock edge.
- Next state is SEND_LO.

Arbitration:
- Round-robin order ALU(0) -> RF(1) -> ERR(2).
- After serving index i, highest priority moves to i+1 mod 3.
- The pointer updates only on a grant.

SEND_LO:
- FIFO_WR = ~FIFO_FULL (combinational); FIFO_WR_DATA = hold[7:0].
- On a write, next state is SEND_HI if the source was ALU, else IDLE.
- If FIFO_FULL, stay in SEND_LO with data unchanged.

SEND_HI:
- FIFO_WR = ~FIFO_FULL; FIFO_WR_DATA = hold[15:8].
- On a write, next state is IDLE; if FIFO_FULL, stay.

Status outputs:
- BUSY = (state != IDLE).
- No grant is issued while BUSY.
- BYTE_CNT increments by 1 on every FIFO_WR=1 cycle and wraps from 2^CNT_WIDTH-1 to 0.

Latency and throughput:
- If the REQ rises in cycle N while in IDLE: GNT in cycle N, first FIFO_WR in N+1 if not full, ALU high byte in N+2.
- There is one mandatory IDLE bubble between transactions.
- Throughput: RF/ERR 1 byte per 2 cycles; ALU 2 bytes per 3 cycles.

Requester rules:
- Dropping REQ before GNT is legal; that request is simply ignored.
- GNT is never asserted for a source whose REQ is low.
- Data is sampled only in the GNT cycle; later changes are ignored.

Simultaneous events:
- All three REQs high with pointer=ALU gives grant order ALU, RF, ERR, ALU...
- FIFO_FULL toggling between the LO and HI bytes stalls only the pending byte. Byte order is preserved; no byte is duplicated or dropped.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, SEND_LO=2'd1, SEND_HI=2'd2) and requester index constants (REQ_ALU=0, REQ_RF=1, REQ_ERR=2).
- Sub-module rr_arbiter: 3 requests, pointer register, one-hot grant, enable input (IDLE only). The pointer advances on a grant.

Test Plan:
1. Reset, then RF_REQ=1 with RF_DATA=0xA5 and FIFO_FULL=0 -> RF_GNT pulses in the request cycle; next cycle FIFO_WR=1 with data 0xA5; BYTE_CNT=1; BUSY falls after.
2. ALU_REQ with ALU_DATA=0x1234 -> FIFO writes 0x34 then 0x12 on consecutive cycles; BYTE_CNT=2.
3. All REQs held high (ALU=0xBEEF, RF=0x11, ERR=0xE1) -> FIFO byte sequence EF, BE, 11, E1, EF, BE...; GNT order ALU, RF, ERR, ALU.
4. ALU_DATA=0xCAFE with FIFO_FULL high for 3 cycles after the LO write -> 0xFE written, FIFO_WR=0 for 3 cycles, then 0xCA; total writes=2.
5. RST pulsed while in SEND_HI of 0x5566 -> no 0x55 write; BYTE_CNT=0; next RF request 0x77 produces a single write of 0x77.
6. 256 RF writes with CNT_WIDTH=8 -> BYTE_CNT wraps to 0; every FIFO_WR cycle coincides with FIFO_FULL=0.
